// File: rtl/elevator_car_model.sv
// elevator_car_model: car, shaft and door plant answering elevator controller commands with FS/DC feedback.
// Optional macro ELEVATOR_FAULT_EN compiles in the sticky illegal-command flag; otherwise fault is tied low.
module elevator_car_model #(
    parameter int         TRAVEL_CYCLES = 8,
    parameter int         DOOR_CYCLES   = 4,
    parameter logic [1:0] START_FLOOR   = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       door,
    input  logic [1:0] direction,
    output logic [1:0] FS,
    output logic       DC,
    output logic       fault
);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_state_t;

    door_state_t   state_q, state_d;
    logic [DW-1:0] door_cnt_q, door_cnt_d;
    logic [1:0]    floor_q, floor_d, target_q, target_d, fs_q, fs_d;
    logic [TW-1:0] trav_cnt_q, trav_cnt_d;
    logic          moving_q, moving_d, dc_q, dc_d;
    logic          up_req, dn_req, depart, arrive;

    assign up_req = direction == 2'b01;
    assign dn_req = direction == 2'b10;

    // door stroke sequencing; a stroke can be reversed at any point and restarts its count
    always_comb begin
        state_d    = state_q;
        door_cnt_d = '0;
        case (state_q)
            CLOSED:  state_d = (door && !moving_q) ? OPENING : CLOSED;
            OPENING: begin
                state_d    = !door ? CLOSING : (door_cnt_q == DOOR_LAST) ? OPEN : OPENING;
                door_cnt_d = (state_d == OPENING) ? door_cnt_q + DW'(1) : '0;
            end
            OPEN:    state_d = door ? OPEN : CLOSING;
            CLOSING: begin
                state_d    = door ? OPENING : (door_cnt_q == DOOR_LAST) ? CLOSED : CLOSING;
                door_cnt_d = (state_d == CLOSING) ? door_cnt_q + DW'(1) : '0;
            end
            default: state_d = CLOSED;
        endcase
    end

    // car motion: a departure commits to the adjacent floor and always runs to completion
    always_comb begin
        depart     = !moving_q && state_q == CLOSED && !door &&
                     ((up_req && floor_q < 2'd3) || (dn_req && floor_q > 2'd1));
        arrive     = moving_q && trav_cnt_q == TRAV_LAST;
        floor_d    = arrive ? target_q : floor_q;
        moving_d   = depart || (moving_q && !arrive);
        target_d   = depart ? (up_req ? floor_q + 2'd1 : floor_q - 2'd1) : target_q;
        trav_cnt_d = (moving_q && !arrive) ? trav_cnt_q + TW'(1) : '0;
        fs_d       = moving_d ? 2'b00 : floor_d;
        dc_d       = state_d == CLOSED;
    end

    // state registers; reset snaps the car to its start floor with the door shut
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLOSED;
            door_cnt_q <= '0;
            floor_q    <= START_FLOOR;
            target_q   <= START_FLOOR;
            moving_q   <= 1'b0;
            trav_cnt_q <= '0;
            fs_q       <= START_FLOOR;
            dc_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            door_cnt_q <= door_cnt_d;
            floor_q    <= floor_d;
            target_q   <= target_d;
            moving_q   <= moving_d;
            trav_cnt_q <= trav_cnt_d;
            fs_q       <= fs_d;
            dc_q       <= dc_d;
        end
    end

    assign FS = fs_q;
    assign DC = dc_q;

`ifdef ELEVATOR_FAULT_EN
    logic fault_q, fault_d, bad_cmd, going_up;

    // any illegal command latches the flag until reset; it never steers motion or door
    always_comb begin
        going_up = target_q > floor_q;
        bad_cmd  = direction == 2'b11 ||
                   (!moving_q && state_q == CLOSED &&
                    ((up_req && floor_q == 2'd3) || (dn_req && floor_q == 2'd1))) ||
                   (moving_q && door) ||
                   (moving_q && (going_up ? dn_req : up_req));
        fault_d  = fault_q || bad_cmd;
    end

    // sticky fault register
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif
endmodule
